// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 serial receiver that packs four LSB-first bytes into one 32-bit word.
// Optional macro RX_TIMEOUT_EN discards a partial word after TIMEOUT_BITS idle bit periods.
module uart_rx_word #(
  parameter int BIT_TICKS    = 2604,
  parameter int HALF_TICKS   = 1302,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [31:0] data_out,
  output logic        rx_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int TICK_W = ($clog2(BIT_TICKS + 1) > 12) ? $clog2(BIT_TICKS + 1) : 12;
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_prev_q, rx_prev_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [23:0]       part_q, part_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              fall_s;

`ifdef RX_TIMEOUT_EN
  localparam int IDLE_LIMIT = TIMEOUT_BITS * BIT_TICKS;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    rx_meta_d   = rx_in;
    rx_s_d      = rx_meta_q;
    rx_prev_d   = rx_s_q;
    fall_s      = rx_prev_q & ~rx_s_q;
    state_d     = state_q;
    tick_d      = tick_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    part_d      = part_q;
    data_out_d  = data_out_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (fall_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_q == HALF_LAST) begin
          tick_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_q == BIT_LAST) begin
          tick_d    = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (tick_q == BIT_LAST) begin
          tick_d = '0;
          if (rx_s_q) begin
            state_d    = IDLE;
            byte_cnt_d = byte_cnt_q + 2'd1;
            // The fourth byte goes straight to data_out; slots 0..2 wait in part_q.
            case (byte_cnt_q)
              2'd0: part_d[7:0]   = shift_q;
              2'd1: part_d[15:8]  = shift_q;
              2'd2: part_d[23:16] = shift_q;
              2'd3: begin
                data_out_d = {shift_q, part_q};
                rx_done_d  = 1'b1;
                busy_d     = 1'b0;
                part_d     = 24'h0;
              end
              default: part_d = 24'h0;
            endcase
          end else begin
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
            byte_cnt_d  = 2'd0;
            busy_d      = 1'b0;
            part_d      = 24'h0;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_IDLE: begin
        tick_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase

`ifdef RX_TIMEOUT_EN
    // Any state other than IDLE is reached only through a falling edge, so the count restarts there.
    idle_cnt_d = '0;
    if ((state_q == IDLE) && !fall_s && (byte_cnt_q != 2'd0)) begin
      if (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1)) begin
        byte_cnt_d = 2'd0;
        busy_d     = 1'b0;
        part_d     = 24'h0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_cnt_q   <= 4'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 8'h0;
      part_q      <= 24'h0;
      data_out_q  <= 32'h0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      part_q      <= part_d;
      data_out_q  <= data_out_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef RX_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
